// File: rtl/vga_sync_ctrl_pkg.sv
// vga_timing_pkg: shared raster timing types and constants for the pong
// display path.
//   axis_state_t     : per-axis scan region (visible, front porch, sync, back porch)
//   *_DEF constants  : 640x480@60 region lengths
//   axis_total()     : line/frame length from the four region lengths
package vga_timing_pkg;

    typedef enum logic [1:0] {
        VIS  = 2'd0,
        FP   = 2'd1,
        SYNC = 2'd2,
        BP   = 2'd3
    } axis_state_t;

    localparam int unsigned H_VIS_DEF  = 640;
    localparam int unsigned H_FP_DEF   = 16;
    localparam int unsigned H_SYNC_DEF = 96;
    localparam int unsigned H_BP_DEF   = 48;

    localparam int unsigned V_VIS_DEF  = 480;
    localparam int unsigned V_FP_DEF   = 10;
    localparam int unsigned V_SYNC_DEF = 2;
    localparam int unsigned V_BP_DEF   = 33;

    function automatic int unsigned axis_total(input int unsigned vis, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return vis + fp + sync + bp;
    endfunction

    localparam int unsigned H_TOTAL_DEF = axis_total(H_VIS_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int unsigned V_TOTAL_DEF = axis_total(V_VIS_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_sync_ctrl_if.sv
// vga_sync_ctrl_if: pixel qualifier in, raster timing out.
//   pix_en                 : pixel advance qualifier (one clk wide)
//   hsync, vsync           : sync outputs, polarity already applied
//   video_on               : inside the visible window
//   x, y                   : current scan position
//   line_start, frame_start: one-clk strobes when x (and y) become 0
// master = timing controller, slave = display/renderer side.
interface vga_sync_ctrl_if;
    logic       pix_en;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] x;
    logic [9:0] y;
    logic       line_start;
    logic       frame_start;

    modport master (
        input  pix_en,
        output hsync, vsync, video_on, x, y, line_start, frame_start
    );

    modport slave (
        output pix_en,
        input  hsync, vsync, video_on, x, y, line_start, frame_start
    );
endinterface

// File: rtl/vga_sync_ctrl_axis_timer.sv
// vga_axis_timer: one scan axis (horizontal or vertical). Counts 0..TOTAL-1
// on each advance and tracks which region the count is in.
//   clk, rst  : system clock, async active-high reset
//   advance   : step the count by one
//   count     : current position
//   state     : current region
//   in_sync   : state is SYNC
//   active    : state is VIS
//   wrap      : combinational, advance while at TOTAL-1
//
// state | meaning
// VIS   | count in [0, VIS_LEN-1]
// FP    | count in [VIS_LEN, VIS_LEN+FP_LEN-1]
// SYNC  | count in [VIS_LEN+FP_LEN, VIS_LEN+FP_LEN+SYNC_LEN-1]
// BP    | count in [VIS_LEN+FP_LEN+SYNC_LEN, TOTAL-1]; also the reset state
module vga_axis_timer
    import vga_timing_pkg::*;
#(
    parameter int unsigned VIS_LEN  = H_VIS_DEF,
    parameter int unsigned FP_LEN   = H_FP_DEF,
    parameter int unsigned SYNC_LEN = H_SYNC_DEF,
    parameter int unsigned BP_LEN   = H_BP_DEF,
    parameter int unsigned TOTAL    = axis_total(VIS_LEN, FP_LEN, SYNC_LEN, BP_LEN)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    output logic [9:0]  count,
    output axis_state_t state,
    output logic        in_sync,
    output logic        active,
    output logic        wrap
);

    localparam logic [9:0] LAST       = 10'(TOTAL - 1);
    localparam logic [9:0] FP_START   = 10'(VIS_LEN);
    localparam logic [9:0] SYNC_START = 10'(VIS_LEN + FP_LEN);
    localparam logic [9:0] BP_START   = 10'(VIS_LEN + FP_LEN + SYNC_LEN);

    logic [9:0]  count_d, count_q;
    axis_state_t state_d, state_q;

    assign wrap = advance && (count_q == LAST);

    // Region changes are decided on the incoming count so state and count
    // always land together on the same edge.
    always_comb begin
        count_d = count_q;
        state_d = state_q;
        if (wrap) begin
            count_d = '0;
            state_d = VIS;
        end else if (advance) begin
            count_d = count_q + 10'd1;
            if (count_d == FP_START)
                state_d = FP;
            else if (count_d == SYNC_START)
                state_d = SYNC;
            else if (count_d == BP_START)
                state_d = BP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= LAST;
            state_q <= BP;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    assign count   = count_q;
    assign state   = state_q;
    assign in_sync = (state_q == SYNC);
    assign active  = (state_q == VIS);

endmodule

// File: rtl/vga_sync_ctrl.sv
// vga_sync_ctrl: raster timing controller. Steps the horizontal axis on each
// pix_en, the vertical axis on each horizontal wrap, and produces sync,
// video window, coordinates and line/frame strobes, all on clk.
//   clk : 100 MHz system clock
//   rst : asynchronous, active-high reset
//   bus : vga_sync_ctrl_if.master (pix_en in, timing outputs out)
module vga_sync_ctrl
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VIS    = H_VIS_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_VIS    = V_VIS_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    vga_sync_ctrl_if.master bus
);

    localparam int unsigned H_TOTAL = axis_total(H_VIS, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_VIS, V_FP, V_SYNC, V_BP);

    logic [9:0]  h_count, v_count;
    axis_state_t h_state, v_state;
    logic        h_in_sync, v_in_sync;
    logic        h_active, v_active;
    logic        h_wrap, v_wrap;

    logic line_start_d, line_start_q;
    logic frame_start_d, frame_start_q;

    vga_axis_timer #(
        .VIS_LEN (H_VIS),
        .FP_LEN  (H_FP),
        .SYNC_LEN(H_SYNC),
        .BP_LEN  (H_BP),
        .TOTAL   (H_TOTAL)
    ) u_h_timer (
        .clk    (clk),
        .rst    (rst),
        .advance(bus.pix_en),
        .count  (h_count),
        .state  (h_state),
        .in_sync(h_in_sync),
        .active (h_active),
        .wrap   (h_wrap)
    );

    vga_axis_timer #(
        .VIS_LEN (V_VIS),
        .FP_LEN  (V_FP),
        .SYNC_LEN(V_SYNC),
        .BP_LEN  (V_BP),
        .TOTAL   (V_TOTAL)
    ) u_v_timer (
        .clk    (clk),
        .rst    (rst),
        .advance(h_wrap),
        .count  (v_count),
        .state  (v_state),
        .in_sync(v_in_sync),
        .active (v_active),
        .wrap   (v_wrap)
    );

    // A wrap on this edge means the counters become 0 on this edge, so the
    // strobes register together with the counters.
    always_comb begin
        line_start_d  = h_wrap;
        frame_start_d = h_wrap && v_wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Sync, window and coordinates are direct decodes of the timer flops.
    assign bus.hsync       = h_in_sync ? SYNC_POL : ~SYNC_POL;
    assign bus.vsync       = v_in_sync ? SYNC_POL : ~SYNC_POL;
    assign bus.video_on    = h_active && v_active;
    assign bus.x           = h_count;
    assign bus.y           = v_count;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;

    // The visible region must match the coordinate range on both axes.
    a_h_vis_region: assert property (@(posedge clk) disable iff (rst)
        (h_state == VIS) == (h_count < 10'(H_VIS)));
    a_v_vis_region: assert property (@(posedge clk) disable iff (rst)
        (v_state == VIS) == (v_count < 10'(V_VIS)));

endmodule

// File: tb/tb_vga_sync_ctrl.sv
module tb_vga_sync_ctrl;

    logic clk;
    logic rst;
    int   total_cnt;
    int   bad_cnt;

    vga_sync_ctrl_if vif_a ();
    vga_sync_ctrl_if vif_b ();

    // Default 640x480 timing, active-low sync.
    vga_sync_ctrl dut_a (
        .clk(clk),
        .rst(rst),
        .bus(vif_a)
    );

    // Tiny raster so whole frames fit in the run: H 8/2/3/3 (16), V 6/1/2/1 (10),
    // active-high sync.
    vga_sync_ctrl #(
        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b1)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(vif_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {x, y, hsync, vsync, video_on, line_start, frame_start}
    function automatic logic [24:0] obs_a();
        return {vif_a.x, vif_a.y, vif_a.hsync, vif_a.vsync, vif_a.video_on,
                vif_a.line_start, vif_a.frame_start};
    endfunction

    function automatic logic [24:0] obs_b();
        return {vif_b.x, vif_b.y, vif_b.hsync, vif_b.vsync, vif_b.video_on,
                vif_b.line_start, vif_b.frame_start};
    endfunction

    function automatic logic [24:0] vec(input int xv, input int yv, input logic hs,
                                        input logic vs, input logic vo, input logic ls,
                                        input logic fs);
        return {10'(xv), 10'(yv), hs, vs, vo, ls, fs};
    endfunction

    // One clk with the given pix_en values; returns #1 after the edge.
    task automatic step(input logic pa, input logic pb);
        vif_a.pix_en = pa;
        vif_b.pix_en = pb;
        @(posedge clk);
        #1;
        vif_a.pix_en = 1'b0;
        vif_b.pix_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [24:0] want;
        rst = 1'b1;
        vif_a.pix_en = 1'b0;
        vif_b.pix_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        want = vec(799, 524, 1, 1, 0, 0, 0);
        total_cnt++;
        if (obs_a() !== want) begin
            bad_cnt++;
            $display("FAIL reset_a: got=%h want=%h", obs_a(), want);
        end
        want = vec(15, 9, 0, 0, 0, 0, 0);
        total_cnt++;
        if (obs_b() !== want) begin
            bad_cnt++;
            $display("FAIL reset_b: got=%h want=%h", obs_b(), want);
        end
        repeat (3) step(1'b0, 1'b0);
        want = vec(799, 524, 1, 1, 0, 0, 0);
        total_cnt++;
        if (obs_a() !== want) begin
            bad_cnt++;
            $display("FAIL reset_idle_a: got=%h want=%h", obs_a(), want);
        end
        step(1'b1, 1'b1);
        want = vec(0, 0, 1, 1, 1, 1, 1);
        total_cnt++;
        if (obs_a() !== want) begin
            bad_cnt++;
            $display("FAIL first_pix_a: got=%h want=%h", obs_a(), want);
        end
        want = vec(0, 0, 0, 0, 1, 1, 1);
        total_cnt++;
        if (obs_b() !== want) begin
            bad_cnt++;
            $display("FAIL first_pix_b: got=%h want=%h", obs_b(), want);
        end
        step(1'b0, 1'b0);
        want = vec(0, 0, 1, 1, 1, 0, 0);
        total_cnt++;
        if (obs_a() !== want) begin
            bad_cnt++;
            $display("FAIL strobe_drop_a: got=%h want=%h", obs_a(), want);
        end
        want = vec(0, 0, 0, 0, 1, 0, 0);
        total_cnt++;
        if (obs_b() !== want) begin
            bad_cnt++;
            $display("FAIL strobe_drop_b: got=%h want=%h", obs_b(), want);
        end
    endtask

    // pix_en every 4th clk across the rest of line 0.
    task automatic test_hscan();
        logic [24:0] want;
        int          hs_low;
        hs_low = 0;
        for (int i = 1; i < 800; i++) begin
            repeat (3) step(1'b0, 1'b0);
            step(1'b1, 1'b0);
            want = vec(i, 0, !(i >= 656 && i <= 751), 1, (i < 640), 0, 0);
            if (vif_a.hsync === 1'b0) hs_low++;
            total_cnt++;
            if (obs_a() !== want) begin
                bad_cnt++;
                $display("FAIL hscan x=%0d: got=%h want=%h", i, obs_a(), want);
            end
        end
        total_cnt++;
        if (hs_low !== 96) begin
            bad_cnt++;
            $display("FAIL hsync_width: got=%0d want=96", hs_low);
        end
    endtask

    task automatic test_line_wrap();
        logic [24:0] want;
        step(1'b1, 1'b0);
        want = vec(0, 1, 1, 1, 1, 1, 0);
        total_cnt++;
        if (obs_a() !== want) begin
            bad_cnt++;
            $display("FAIL line_wrap: got=%h want=%h", obs_a(), want);
        end
        step(1'b0, 1'b0);
        want = vec(0, 1, 1, 1, 1, 0, 0);
        total_cnt++;
        if (obs_a() !== want) begin
            bad_cnt++;
            $display("FAIL line_strobe_drop: got=%h want=%h", obs_a(), want);
        end
    endtask

    task automatic test_freeze();
        logic [24:0] want_a;
        logic [24:0] want_b;
        want_a = vec(0, 1, 1, 1, 1, 0, 0);
        want_b = vec(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b0);
            total_cnt++;
            if (obs_a() !== want_a || obs_b() !== want_b) begin
                bad_cnt++;
                $display("FAIL freeze clk=%0d: got=%h/%h want=%h/%h", i, obs_a(), obs_b(),
                         want_a, want_b);
            end
        end
    endtask

    // pix_en held high: one pixel per clk, through a line wrap, on to x=300.
    task automatic test_back_to_back();
        logic [24:0] want;
        int          xe;
        int          ye;
        for (int i = 1; i <= 1100; i++) begin
            step(1'b1, 1'b0);
            xe = i % 800;
            ye = (i >= 800) ? 2 : 1;
            want = vec(xe, ye, !(xe >= 656 && xe <= 751), 1, (xe < 640), (xe == 0), 0);
            total_cnt++;
            if (obs_a() !== want) begin
                bad_cnt++;
                $display("FAIL b2b i=%0d: got=%h want=%h", i, obs_a(), want);
            end
        end
    endtask

    // Small raster, pix_en held high for two full frames (2 x 160 pixels).
    task automatic test_frame();
        logic [24:0] want;
        int          ex;
        int          ey;
        int          fs_seen;
        int          last_fs;
        int          vs_act;
        ex      = 0;
        ey      = 0;
        fs_seen = 0;
        last_fs = 0;
        vs_act  = 0;
        for (int i = 1; i <= 320; i++) begin
            step(1'b0, 1'b1);
            if (ex == 15) begin
                ex = 0;
                ey = (ey == 9) ? 0 : ey + 1;
            end else begin
                ex++;
            end
            want = vec(ex, ey, (ex >= 10 && ex <= 12), (ey >= 7 && ey <= 8),
                       (ex < 8 && ey < 6), (ex == 0), (ex == 0 && ey == 0));
            total_cnt++;
            if (obs_b() !== want) begin
                bad_cnt++;
                $display("FAIL frame i=%0d: got=%h want=%h", i, obs_b(), want);
            end
            if (vif_b.vsync === 1'b1) vs_act++;
            if (vif_b.frame_start === 1'b1) begin
                fs_seen++;
                total_cnt++;
                if ((i - last_fs) !== 160) begin
                    bad_cnt++;
                    $display("FAIL frame_period: got=%0d want=160", i - last_fs);
                end
                last_fs = i;
            end
        end
        total_cnt++;
        if (fs_seen !== 2) begin
            bad_cnt++;
            $display("FAIL frame_count: got=%0d want=2", fs_seen);
        end
        total_cnt++;
        if (vs_act !== 64) begin
            bad_cnt++;
            $display("FAIL vsync_width: got=%0d want=64", vs_act);
        end
    endtask

    task automatic test_mid_reset();
        logic [24:0] want;
        want = vec(300, 2, 1, 1, 1, 0, 0);
        total_cnt++;
        if (obs_a() !== want) begin
            bad_cnt++;
            $display("FAIL pre_reset_pos: got=%h want=%h", obs_a(), want);
        end
        #3;
        rst = 1'b1;
        #1;
        want = vec(799, 524, 1, 1, 0, 0, 0);
        total_cnt++;
        if (obs_a() !== want) begin
            bad_cnt++;
            $display("FAIL async_reset_a: got=%h want=%h", obs_a(), want);
        end
        want = vec(15, 9, 0, 0, 0, 0, 0);
        total_cnt++;
        if (obs_b() !== want) begin
            bad_cnt++;
            $display("FAIL async_reset_b: got=%h want=%h", obs_b(), want);
        end
        vif_a.pix_en = 1'b1;
        @(posedge clk);
        #1;
        vif_a.pix_en = 1'b0;
        rst = 1'b0;
        want = vec(799, 524, 1, 1, 0, 0, 0);
        total_cnt++;
        if (obs_a() !== want) begin
            bad_cnt++;
            $display("FAIL reset_hold: got=%h want=%h", obs_a(), want);
        end
        repeat (3) step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        want = vec(0, 0, 1, 1, 1, 1, 1);
        total_cnt++;
        if (obs_a() !== want) begin
            bad_cnt++;
            $display("FAIL restart_a: got=%h want=%h", obs_a(), want);
        end
        want = vec(0, 0, 0, 0, 1, 1, 1);
        total_cnt++;
        if (obs_b() !== want) begin
            bad_cnt++;
            $display("FAIL restart_b: got=%h want=%h", obs_b(), want);
        end
        step(1'b0, 1'b0);
        want = vec(0, 0, 1, 1, 1, 0, 0);
        total_cnt++;
        if (obs_a() !== want) begin
            bad_cnt++;
            $display("FAIL restart_drop: got=%h want=%h", obs_a(), want);
        end
    endtask

    initial begin
        total_cnt    = 0;
        bad_cnt      = 0;
        rst          = 1'b1;
        vif_a.pix_en = 1'b0;
        vif_b.pix_en = 1'b0;
        test_reset();
        test_hscan();
        test_line_wrap();
        test_freeze();
        test_back_to_back();
        test_frame();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
